// File: rtl/dac_window_fsm_n_if.sv
// rtl/dac_window_fsm_n_if.sv - sample, config and status bundle for one DAC channel window discriminator
interface dac_window_fsm_n_if #(
  parameter int N_WIN = 4,
  parameter int DW    = 16,
  parameter int CW    = 16
);
  logic                  fsm_en;
  logic                  sample_valid;
  logic [DW-1:0]         sample;
  logic [N_WIN*DW-1:0]   thrsh;
  logic [N_WIN-1:0]      thrsh_pol;
  logic [N_WIN-1:0]      edge_type;
  logic [N_WIN-1:0]      win_en;
  logic [N_WIN*CW-1:0]   start_win;
  logic [N_WIN*CW-1:0]   stop_win;
  logic [CW-1:0]         stop_max;
  logic [CW-1:0]         refractory;
  logic                  detect;
  logic                  busy;
  logic [N_WIN-1:0]      win_hit;
  logic [1:0]            state;
  logic [CW-1:0]         sample_cnt;
  logic [15:0]           match_cnt;

  modport master (
    output fsm_en, sample_valid, sample, thrsh, thrsh_pol, edge_type, win_en,
           start_win, stop_win, stop_max, refractory,
    input  detect, busy, win_hit, state, sample_cnt, match_cnt
  );

  modport slave (
    input  fsm_en, sample_valid, sample, thrsh, thrsh_pol, edge_type, win_en,
           start_win, stop_win, stop_max, refractory,
    output detect, busy, win_hit, state, sample_cnt, match_cnt
  );
endinterface

// File: rtl/dac_window_fsm_n.sv
// rtl/dac_window_fsm_n.sv - N-window spike discriminator with config shadowing, refractory lockout and match counter
module dac_window_fsm_n #(
  parameter int N_WIN = 4,
  parameter int DW    = 16,
  parameter int CW    = 16
) (
  input  logic             dataclk,
  input  logic             reset_n,
  dac_window_fsm_n_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_TRACK   = 2'd1;
  localparam logic [1:0] S_REFRACT = 2'd2;

  logic [1:0]          r_state;
  logic                r_detect;
  logic [N_WIN-1:0]    r_win_hit;
  logic [CW-1:0]       r_sample_cnt;
  logic [CW-1:0]       r_refr_left;
  logic [15:0]         r_match_cnt;

  // Shadow copies of the config, frozen at trigger time
  logic [N_WIN*DW-1:0] r_thrsh;
  logic [N_WIN-1:0]    r_pol;
  logic [N_WIN-1:0]    r_edge;
  logic [N_WIN-1:0]    r_en;
  logic [N_WIN*CW-1:0] r_start;
  logic [N_WIN*CW-1:0] r_stop;
  logic [CW-1:0]       r_stop_max;
  logic [CW-1:0]       r_refr;

  logic                w_idle;
  logic [N_WIN*DW-1:0] w_thrsh;
  logic [N_WIN-1:0]    w_pol;
  logic [N_WIN-1:0]    w_edge;
  logic [N_WIN-1:0]    w_en;
  logic [N_WIN*CW-1:0] w_start;
  logic [N_WIN*CW-1:0] w_stop;
  logic [CW-1:0]       w_stop_max;
  logic [CW-1:0]       w_refr;
  logic [CW-1:0]       w_idx;
  logic [N_WIN-1:0]    w_hit_prev;
  logic [N_WIN-1:0]    w_cross;
  logic [N_WIN-1:0]    w_hit_next;
  logic [N_WIN-1:0]    w_viol;
  logic [N_WIN-1:0]    w_miss;
  logic [N_WIN-1:0]    w_sat;
  logic                w_trigger;
  logic                w_at_end;
  logic                w_abort;
  logic                w_match;
  logic                w_eval;

  // The trigger sample is judged against live config, which is what gets latched
  assign w_idle     = (r_state == S_IDLE);
  assign w_thrsh    = w_idle ? bus.thrsh      : r_thrsh;
  assign w_pol      = w_idle ? bus.thrsh_pol  : r_pol;
  assign w_edge     = w_idle ? bus.edge_type  : r_edge;
  assign w_en       = w_idle ? bus.win_en     : r_en;
  assign w_start    = w_idle ? bus.start_win  : r_start;
  assign w_stop     = w_idle ? bus.stop_win   : r_stop;
  assign w_stop_max = w_idle ? bus.stop_max   : r_stop_max;
  assign w_refr     = w_idle ? bus.refractory : r_refr;
  assign w_idx      = w_idle ? '0 : r_sample_cnt + CW'(1);
  assign w_hit_prev = w_idle ? '0 : r_win_hit;

  for (genvar k = 0; k < N_WIN; k++) begin : g_win
    logic [DW-1:0] w_thr;
    logic [CW-1:0] w_lo;
    logic [CW-1:0] w_hi_raw;
    logic [CW-1:0] w_hi;
    logic          w_live;
    logic          w_active;

    assign w_thr      = w_thrsh[k*DW +: DW];
    assign w_lo       = w_start[k*CW +: CW];
    assign w_hi_raw   = w_stop[k*CW +: CW];
    // Bounds past the final index are clipped; an empty window counts as satisfied
    assign w_hi       = (w_hi_raw > w_stop_max) ? w_stop_max : w_hi_raw;
    assign w_live     = w_en[k] && (w_lo <= w_hi);
    assign w_active   = w_live && (w_idx >= w_lo) && (w_idx <= w_hi);
    assign w_cross[k] = w_pol[k] ? (bus.sample >= w_thr) : (bus.sample <= w_thr);
    assign w_hit_next[k] = w_hit_prev[k] | (w_active & ~w_edge[k] & w_cross[k]);
    assign w_viol[k]  = w_active & w_edge[k] & w_cross[k];
    assign w_miss[k]  = w_live && !w_edge[k] && (w_idx > w_hi) && !w_hit_next[k];
    assign w_sat[k]   = !w_live || w_edge[k] || w_hit_next[k];
  end

  assign w_trigger = w_idle && bus.win_en[0] && w_cross[0];
  assign w_at_end  = (w_idx == w_stop_max);
  // An exclusion hit on the final sample beats a completed match
  assign w_abort   = (|w_viol) || (|w_miss) || (w_at_end && !(&w_sat));
  assign w_match   = w_at_end && !w_abort;
  assign w_eval    = bus.sample_valid && (w_trigger || (r_state == S_TRACK));

  // Capture the config on the trigger sample so later edits only affect the next trial
  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      r_thrsh    <= '0;
      r_pol      <= '0;
      r_edge     <= '0;
      r_en       <= '0;
      r_start    <= '0;
      r_stop     <= '0;
      r_stop_max <= '0;
      r_refr     <= '0;
    end else if (bus.fsm_en && bus.sample_valid && w_trigger) begin
      r_thrsh    <= bus.thrsh;
      r_pol      <= bus.thrsh_pol;
      r_edge     <= bus.edge_type;
      r_en       <= bus.win_en;
      r_start    <= bus.start_win;
      r_stop     <= bus.stop_win;
      r_stop_max <= bus.stop_max;
      r_refr     <= bus.refractory;
    end
  end

  // Trial sequencing: trigger, per-sample window tracking, detect and refractory countdown
  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_detect     <= 1'b0;
      r_win_hit    <= '0;
      r_sample_cnt <= '0;
      r_refr_left  <= '0;
      r_match_cnt  <= '0;
    end else if (!bus.fsm_en) begin
      r_state   <= S_IDLE;
      r_detect  <= 1'b0;
      r_win_hit <= '0;
    end else begin
      r_detect <= 1'b0;
      if (w_eval) begin
        r_sample_cnt <= w_idx;
        r_win_hit    <= w_hit_next;
        if (w_abort) begin
          r_state <= S_IDLE;
        end else if (w_match) begin
          r_detect    <= 1'b1;
          r_match_cnt <= (r_match_cnt == 16'hFFFF) ? r_match_cnt : r_match_cnt + 16'd1;
          r_refr_left <= w_refr - CW'(1);
          r_state     <= (w_refr == '0) ? S_IDLE : S_REFRACT;
        end else begin
          r_state <= S_TRACK;
        end
      end else if (bus.sample_valid && (r_state == S_REFRACT)) begin
        if (r_refr_left == '0) r_state <= S_IDLE;
        else                   r_refr_left <= r_refr_left - CW'(1);
      end
    end
  end

  assign bus.detect     = r_detect;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.win_hit    = r_win_hit;
  assign bus.state      = r_state;
  assign bus.sample_cnt = r_sample_cnt;
  assign bus.match_cnt  = r_match_cnt;

endmodule

// File: tb/tb_dac_window_fsm_n.sv
// tb/tb_dac_window_fsm_n.sv - directed self-checking bench for dac_window_fsm_n
module tb_dac_window_fsm_n;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   det_cnt  = 0;

  always #5 clk = ~clk;

  dac_window_fsm_n_if #(.N_WIN(4), .DW(16), .CW(16)) ifc ();

  dac_window_fsm_n #(.N_WIN(4), .DW(16), .CW(16)) u_dut (
    .dataclk (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One sample per call: starts and ends on a falling edge
  task automatic send(input logic [15:0] v);
    ifc.sample       = v;
    ifc.sample_valid = 1'b1;
    @(negedge clk);
    ifc.sample_valid = 1'b0;
  endtask

  task automatic send_n(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) send(v);
  endtask

  always @(negedge clk) if (reset_n && ifc.detect === 1'b1) det_cnt++;

  initial begin
    reset_n          = 1'b0;
    ifc.fsm_en       = 1'b1;
    ifc.sample_valid = 1'b0;
    ifc.sample       = 16'h8000;
    ifc.thrsh        = {16'hB000, 16'hA000, 16'h6000, 16'h9000};
    ifc.thrsh_pol    = 4'b1101;
    ifc.edge_type    = 4'b1110;
    ifc.win_en       = 4'b1111;
    ifc.start_win    = {16'd5, 16'd5, 16'd1, 16'd0};
    ifc.stop_win     = {16'd9, 16'd8, 16'd7, 16'd1};
    ifc.stop_max     = 16'd9;
    ifc.refractory   = 16'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_state", ifc.state, 0);
    check_eq("rst_busy", ifc.busy, 0);
    check_eq("rst_detect", ifc.detect, 0);
    check_eq("rst_win_hit", ifc.win_hit, 0);
    check_eq("rst_sample_cnt", ifc.sample_cnt, 0);
    check_eq("rst_match_cnt", ifc.match_cnt, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // T1: full inclusion trial, detect on idx 9
    send(16'h9800);
    check_eq("t1_trig_state", ifc.state, 1);
    check_eq("t1_trig_busy", ifc.busy, 1);
    check_eq("t1_trig_hit", ifc.win_hit, 4'b0001);
    check_eq("t1_trig_cnt", ifc.sample_cnt, 0);
    send_n(16'h8000, 8);
    check_eq("t1_idx8_cnt", ifc.sample_cnt, 8);
    check_eq("t1_idx8_detect", ifc.detect, 0);
    send(16'h8000);
    check_eq("t1_detect", ifc.detect, 1);
    check_eq("t1_match", ifc.match_cnt, 1);
    check_eq("t1_state", ifc.state, 0);
    check_eq("t1_cnt", ifc.sample_cnt, 9);
    send(16'h8000);
    check_eq("t1_pulse_end", ifc.detect, 0);
    check_eq("t1_hit_kept", ifc.win_hit, 4'b0001);

    // T2: exclusion window 2 crossed at idx 6
    send(16'h9800);
    send_n(16'h8000, 5);
    send(16'hA800);
    check_eq("t2_state", ifc.state, 0);
    check_eq("t2_detect", ifc.detect, 0);
    check_eq("t2_hit", ifc.win_hit, 4'b0001);
    check_eq("t2_cnt", ifc.sample_cnt, 6);
    check_eq("t2_match", ifc.match_cnt, 1);

    // Exclusion window 3 crossed on the stop_max sample: abort wins
    send(16'h9800);
    send_n(16'h8000, 8);
    send(16'hB800);
    check_eq("excl_end_detect", ifc.detect, 0);
    check_eq("excl_end_state", ifc.state, 0);
    check_eq("excl_end_match", ifc.match_cnt, 1);

    // T4: threshold 1 edited mid-trial only affects the next trial
    send(16'h9800);
    ifc.thrsh[31:16] = 16'h8000;
    send_n(16'h8000, 8);
    check_eq("t4_mid_state", ifc.state, 1);
    send(16'h8000);
    check_eq("t4_detect", ifc.detect, 1);
    check_eq("t4_match", ifc.match_cnt, 2);
    send(16'h9800);
    send(16'h8000);
    check_eq("t4_new_thr_state", ifc.state, 0);
    check_eq("t4_new_thr_cnt", ifc.sample_cnt, 1);
    check_eq("t4_new_thr_match", ifc.match_cnt, 2);
    ifc.thrsh[31:16] = 16'h6000;

    // T3: refractory 20 swallows a spike 10 samples later
    ifc.refractory = 16'd20;
    send(16'h9800);
    send_n(16'h8000, 9);
    check_eq("t3_detect1", ifc.detect, 1);
    check_eq("t3_match1", ifc.match_cnt, 3);
    check_eq("t3_refract", ifc.state, 2);
    send(16'h9800);
    check_eq("t3_ignored_state", ifc.state, 2);
    check_eq("t3_ignored_detect", ifc.detect, 0);
    send_n(16'h8000, 18);
    check_eq("t3_s28_state", ifc.state, 2);
    send(16'h8000);
    check_eq("t3_s29_state", ifc.state, 0);
    send_n(16'h8000, 10);
    send(16'h9800);
    check_eq("t3_retrig", ifc.state, 1);
    send_n(16'h8000, 9);
    check_eq("t3_detect2", ifc.detect, 1);
    check_eq("t3_match2", ifc.match_cnt, 4);
    send_n(16'h8000, 20);
    check_eq("t3_refract_done", ifc.state, 0);
    ifc.refractory = 16'd0;

    // T5: async reset mid-trial, then fsm_en drop on the would-be detect sample
    send(16'h9800);
    send_n(16'h8000, 4);
    check_eq("t5_cnt4", ifc.sample_cnt, 4);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t5_rst_state", ifc.state, 0);
    check_eq("t5_rst_busy", ifc.busy, 0);
    check_eq("t5_rst_cnt", ifc.sample_cnt, 0);
    check_eq("t5_rst_hit", ifc.win_hit, 0);
    check_eq("t5_rst_match", ifc.match_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(16'h9800);
    send_n(16'h8000, 8);
    ifc.fsm_en = 1'b0;
    send(16'h8000);
    check_eq("t5_en_detect", ifc.detect, 0);
    check_eq("t5_en_state", ifc.state, 0);
    check_eq("t5_en_hit", ifc.win_hit, 0);
    check_eq("t5_en_match", ifc.match_cnt, 0);
    ifc.fsm_en = 1'b1;

    // T6: single-window mode with refractory 2
    ifc.stop_max   = 16'd0;
    ifc.win_en     = 4'b0001;
    ifc.refractory = 16'd2;
    send(16'h9800);
    check_eq("t6_detect1", ifc.detect, 1);
    check_eq("t6_match1", ifc.match_cnt, 1);
    check_eq("t6_state1", ifc.state, 2);
    send(16'h9800);
    check_eq("t6_lock_detect", ifc.detect, 0);
    check_eq("t6_lock_state", ifc.state, 2);
    send(16'h9800);
    check_eq("t6_lock_end", ifc.state, 0);
    send(16'h9000);
    check_eq("t6_eq_detect", ifc.detect, 1);
    check_eq("t6_match2", ifc.match_cnt, 2);
    send_n(16'h8000, 2);
    send(16'h8FFF);
    check_eq("t6_below_detect", ifc.detect, 0);
    check_eq("t6_below_state", ifc.state, 0);
    check_eq("t6_match_final", ifc.match_cnt, 2);

    repeat (3) @(negedge clk);
    check_eq("detect_pulses", det_cnt, 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
